// File: rtl/rf_dump_reader.sv
// Sequential register-file dump reader: walks an address range through one RF read port and
// streams {address, data} words over valid/ready while keeping a running 32-bit checksum.
module rf_dump_reader #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DATA_W  = 32,
    parameter bit          SKIP_R0 = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Start,
    input  logic [ADDR_W-1:0] FirstAddr,
    input  logic [ADDR_W-1:0] LastAddr,
    output logic [ADDR_W-1:0] Ard,
    input  logic [DATA_W-1:0] RdData,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [ADDR_W-1:0] OutAddr,
    output logic [DATA_W-1:0] OutData,
    output logic [DATA_W-1:0] Checksum,
    output logic              Busy,
    output logic              Done,
    output logic              Err
);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StSend,
        StFin
    } state_e;

    state_e              r_state;
    logic [ADDR_W-1:0]   r_cur;
    logic [ADDR_W-1:0]   r_last;
    logic                r_out_valid;
    logic [ADDR_W-1:0]   r_out_addr;
    logic [DATA_W-1:0]   r_out_data;
    logic [DATA_W-1:0]   r_checksum;
    logic                r_err;

    state_e              w_state_nxt;
    logic [ADDR_W-1:0]   w_cur_nxt;
    logic [ADDR_W-1:0]   w_last_nxt;
    logic                w_out_valid_nxt;
    logic [ADDR_W-1:0]   w_out_addr_nxt;
    logic [DATA_W-1:0]   w_out_data_nxt;
    logic [DATA_W-1:0]   w_checksum_nxt;
    logic                w_err_nxt;
    logic [ADDR_W-1:0]   w_first_eff;
    logic                w_skip_all;
    logic                w_at_end;

    // Register 0 is hard-wired zero, so the walk starts at 1 when skipping it.
    assign w_first_eff = (SKIP_R0 && (FirstAddr == '0)) ? ADDR_W'(1) : FirstAddr;
    assign w_skip_all  = SKIP_R0 && (LastAddr == '0);
    assign w_at_end    = (r_cur == r_last) || (r_cur == '1);

    always_comb begin
        w_state_nxt     = r_state;
        w_cur_nxt       = r_cur;
        w_last_nxt      = r_last;
        w_out_valid_nxt = r_out_valid;
        w_out_addr_nxt  = r_out_addr;
        w_out_data_nxt  = r_out_data;
        w_checksum_nxt  = r_checksum;
        w_err_nxt       = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (Start) begin
                    if (FirstAddr > LastAddr) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_cur_nxt      = w_first_eff;
                        w_last_nxt     = LastAddr;
                        w_checksum_nxt = '0;
                        w_state_nxt    = w_skip_all ? StFin : StFetch;
                    end
                end
            end
            StFetch: begin
                w_out_data_nxt  = RdData;
                w_out_addr_nxt  = r_cur;
                w_out_valid_nxt = 1'b1;
                w_state_nxt     = StSend;
            end
            StSend: begin
                if (r_out_valid && OutReady) begin
                    w_checksum_nxt  = r_checksum + r_out_data;
                    w_out_valid_nxt = 1'b0;
                    if (w_at_end) begin
                        w_state_nxt = StFin;
                    end else begin
                        w_cur_nxt   = r_cur + ADDR_W'(1);
                        w_state_nxt = StFetch;
                    end
                end
            end
            StFin: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= StIdle;
            r_cur       <= '0;
            r_last      <= '0;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
            r_checksum  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cur       <= w_cur_nxt;
            r_last      <= w_last_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_addr  <= w_out_addr_nxt;
            r_out_data  <= w_out_data_nxt;
            r_checksum  <= w_checksum_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign Ard      = r_cur;
    assign OutValid = r_out_valid;
    assign OutAddr  = r_out_addr;
    assign OutData  = r_out_data;
    assign Checksum = r_checksum;
    assign Busy     = (r_state == StFetch) || (r_state == StSend);
    assign Done     = (r_state == StFin);
    assign Err      = r_err;

endmodule

// File: tb/tb_rf_dump_reader.sv
// Scoreboard bench for rf_dump_reader: expected words are queued at Start and popped on
// each output handshake; a behavioural RF supplies combinational read data.
module tb_rf_dump_reader;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              Start = 1'b0;
    logic [ADDR_W-1:0] FirstAddr = '0;
    logic [ADDR_W-1:0] LastAddr = '0;
    logic [ADDR_W-1:0] Ard;
    logic [DATA_W-1:0] RdData;
    logic              OutValid;
    logic              OutReady = 1'b1;
    logic [ADDR_W-1:0] OutAddr;
    logic [DATA_W-1:0] OutData;
    logic [DATA_W-1:0] Checksum;
    logic              Busy;
    logic              Done;
    logic              Err;

    logic [DATA_W-1:0]        rf [32];
    logic [ADDR_W+DATA_W-1:0] sb [$];
    logic [DATA_W-1:0]        exp_sum = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_hs  = 0;
    int hs_in_dump = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int rdy_mode = 0;  // 0: always ready, 1: 0,0,1 per word, 2: never ready
    int rdy_cnt  = 0;
    bit hold_pending = 1'b0;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_data;

    rf_dump_reader #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .SKIP_R0(1'b1)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .Start    (Start),
        .FirstAddr(FirstAddr),
        .LastAddr (LastAddr),
        .Ard      (Ard),
        .RdData   (RdData),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .OutAddr  (OutAddr),
        .OutData  (OutData),
        .Checksum (Checksum),
        .Busy     (Busy),
        .Done     (Done),
        .Err      (Err)
    );

    always #5 CLK = ~CLK;

    assign RdData = rf[Ard];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    always @(posedge CLK) begin
        #1;
        if (!OutValid) begin
            rdy_cnt  = 0;
            OutReady = (rdy_mode == 0);
        end else begin
            OutReady = (rdy_mode == 0) || (rdy_mode == 1 && rdy_cnt >= 2);
            rdy_cnt++;
        end
    end

    // Output monitor: scoreboard pop, hold-stability and Done checks.
    always @(negedge CLK) begin
        cyc++;
        if (RST) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check("hold_valid", 32'(OutValid), 32'd1);
                check("hold_addr", 32'(OutAddr), 32'(h_addr));
                check("hold_data", OutData, h_data);
            end
            if (OutValid && OutReady) begin
                if (sb.size() == 0) begin
                    check("unexpected_word", 32'(OutAddr), 32'hDEAD_BEEF);
                end else begin
                    logic [ADDR_W+DATA_W-1:0] e;
                    e = sb.pop_front();
                    check("word_addr", 32'(OutAddr), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
                    check("word_data", OutData, e[DATA_W-1:0]);
                    exp_sum = exp_sum + e[DATA_W-1:0];
                end
                last_hs = cyc;
                hs_in_dump++;
            end
            hold_pending = OutValid && !OutReady;
            h_addr = OutAddr;
            h_data = OutData;
            if (Done) begin
                done_cnt++;
                check("done_checksum", Checksum, exp_sum);
                check("done_words_left", 32'(sb.size()), 32'd0);
                check("done_busy", 32'(Busy), 32'd0);
                if (hs_in_dump > 0) check("done_latency", 32'(cyc - last_hs), 32'd1);
            end
            if (Err) err_cnt++;
        end
    end

    task automatic start_dump(input int f, input int l);
        int a;
        a = (f == 0) ? 1 : f;
        for (int i = a; i <= l; i++) sb.push_back({ADDR_W'(i), rf[i]});
        exp_sum    = '0;
        hs_in_dump = 0;
        @(posedge CLK); #1;
        Start = 1'b1; FirstAddr = ADDR_W'(f); LastAddr = ADDR_W'(l);
        @(posedge CLK); #1;
        Start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        bit seen;
        d0 = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge CLK);
            if (done_cnt != d0) seen = 1'b1;
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
        @(negedge CLK);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ard"}, 32'(Ard), 32'd0);
        check({tag, "_valid"}, 32'(OutValid), 32'd0);
        check({tag, "_addr"}, 32'(OutAddr), 32'd0);
        check({tag, "_data"}, OutData, 32'd0);
        check({tag, "_sum"}, Checksum, 32'd0);
        check({tag, "_busy"}, 32'(Busy), 32'd0);
        check({tag, "_done"}, 32'(Done), 32'd0);
        check({tag, "_err"}, 32'(Err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int e0;
        logic [DATA_W-1:0] s;
        bit found;

        for (int i = 0; i < 32; i++) rf[i] = 32'(3 * i);
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check_reset_outputs("reset");

        // Full dump with register 0 skipped.
        d0 = done_cnt;
        start_dump(0, 31);
        @(negedge CLK);
        check("full_busy", 32'(Busy), 32'd1);
        wait_done(200);
        check("full_checksum", Checksum, 32'd1488);
        check("full_done_once", 32'(done_cnt - d0), 32'd1);
        repeat (3) @(negedge CLK);
        check("full_busy_after", 32'(Busy), 32'd0);
        check("full_done_once_later", 32'(done_cnt - d0), 32'd1);

        // Rejected range.
        e0 = err_cnt;
        @(posedge CLK); #1;
        Start = 1'b1; FirstAddr = 5'd9; LastAddr = 5'd3;
        @(posedge CLK); #1;
        Start = 1'b0;
        @(negedge CLK);
        check("err_pulse", 32'(Err), 32'd1);
        check("err_valid", 32'(OutValid), 32'd0);
        check("err_busy", 32'(Busy), 32'd0);
        @(negedge CLK);
        check("err_pulse_end", 32'(Err), 32'd0);
        check("err_checksum", Checksum, 32'd1488);
        repeat (3) @(negedge CLK);
        check("err_count", 32'(err_cnt - e0), 32'd1);
        check("err_busy_later", 32'(Busy), 32'd0);

        // Empty range after skipping register 0.
        d0 = done_cnt;
        start_dump(0, 0);
        wait_done(10);
        check("zero_done", 32'(done_cnt - d0), 32'd1);
        check("zero_checksum", Checksum, 32'd0);
        check("zero_words", 32'(hs_in_dump), 32'd0);

        // Backpressure 0,0,1 per word.
        rf[4] = 32'h1234_0004;
        rf[5] = 32'hA5A5_0005;
        rf[6] = 32'h0F0F_0006;
        rdy_mode = 1;
        start_dump(4, 6);
        wait_done(50);
        check("bp_words", 32'(hs_in_dump), 32'd3);
        check("bp_checksum", Checksum, 32'h1234_0004 + 32'hA5A5_0005 + 32'h0F0F_0006);
        rdy_mode = 0;

        // Single word at the top address and checksum wrap.
        rf[31] = 32'hFFFF_FFFF;
        start_dump(31, 31);
        wait_done(20);
        check("single_words", 32'(hs_in_dump), 32'd1);
        check("single_checksum", Checksum, 32'hFFFF_FFFF);
        rf[30] = 32'd1;
        start_dump(30, 31);
        wait_done(20);
        check("wrap_checksum", Checksum, 32'd0);

        // Start pulse during a dump is ignored.
        for (int i = 0; i < 32; i++) rf[i] = 32'(3 * i);
        start_dump(2, 12);
        repeat (3) @(posedge CLK);
        #1;
        Start = 1'b1; FirstAddr = 5'd20; LastAddr = 5'd25;
        @(posedge CLK); #1;
        Start = 1'b0;
        @(negedge CLK);
        check("busy_start_busy", 32'(Busy), 32'd1);
        wait_done(100);
        check("busy_start_words", 32'(hs_in_dump), 32'd11);
        check("busy_start_checksum", Checksum, 32'(3 * (2 + 12) * 11 / 2));
        check("busy_start_no_rerun", 32'(Busy), 32'd0);

        // Reset while the third word waits in SEND.
        rdy_mode = 1;
        d0 = done_cnt;
        start_dump(1, 10);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge CLK);
            if (OutValid && OutAddr == 5'd3) found = 1'b1;
        end
        check("rst_reached_word3", 32'(found), 32'd1);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        sb.delete();
        exp_sum = '0;
        rdy_mode = 0;
        @(negedge CLK);
        check_reset_outputs("midrst");
        check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        start_dump(5, 8);
        wait_done(50);
        s = rf[5] + rf[6] + rf[7] + rf[8];
        check("post_rst_checksum", Checksum, s);
        check("post_rst_words", 32'(hs_in_dump), 32'd4);

        repeat (2) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
